// File: rtl/uart_pixel_assembler.sv
`default_nettype none
// ==========================================================================
// uart_pixel_assembler : packs UART bytes R,G,B into 24-bit frame RAM writes.
// Optional inter-byte timeout compiled in with `define RX_TIMEOUT_EN.  Rev 1.0
// ==========================================================================
module uart_pixel_assembler #(
  parameter int IMG_W       = 240,
  parameter int IMG_H       = 170,
  parameter int TIMEOUT_CYC = 100000,
  localparam int NPIX       = IMG_W * IMG_H,
  localparam int CNT_W      = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic             clk,
  input  logic             reset,       // active low, asynchronous assert
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic [23:0]      pixel_data,
  output logic             pixel_done,
  output logic [CNT_W-1:0] pixel_cnt,
  output logic             frame_done,
  output logic             busy,
  output logic             rx_timeout
);

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_t;

  phase_t     phase, phase_next;
  logic [7:0] r_byte, g_byte;
  logic       timeout_hit;

`ifdef RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts idle cycles only while a pixel is partially received.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      to_cnt <= '0;
    else if (rx_done || phase == PH_R || timeout_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (phase != PH_R) && !rx_done &&
                       (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Timeout compiled out; the comparison keeps TIMEOUT_CYC referenced.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      phase <= PH_R;
    else
      phase <= phase_next;
  end

  always_comb begin
    phase_next = phase;
    if (timeout_hit) begin
      phase_next = PH_R;
    end else if (rx_done) begin
      case (phase)
        PH_R:    phase_next = PH_G;
        PH_G:    phase_next = PH_B;
        default: phase_next = PH_R;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte     <= '0;
      g_byte     <= '0;
      pixel_data <= '0;
      pixel_done <= 1'b0;
      pixel_cnt  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      rx_timeout <= 1'b0;
    end else begin
      pixel_done <= 1'b0;
      frame_done <= 1'b0;
      rx_timeout <= timeout_hit;

      if (rx_done) begin
        case (phase)
          PH_R: r_byte <= rx_data;
          PH_G: g_byte <= rx_data;
          PH_B: begin
            pixel_data <= {r_byte, g_byte, rx_data};
            pixel_done <= 1'b1;
          end
          default: ;
        endcase
      end

      // Address advances the cycle after its write; wraps with frame_done.
      if (pixel_done) begin
        if (pixel_cnt == CNT_W'(NPIX - 1)) begin
          pixel_cnt  <= '0;
          frame_done <= 1'b1;
          busy       <= 1'b0;
        end else begin
          pixel_cnt <= pixel_cnt + 1'b1;
        end
      end

      // A new frame's first R byte wins over the end-of-frame clear.
      if (rx_done && phase == PH_R)
        busy <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_pixel_assembler.sv
`default_nettype none
// tb_uart_pixel_assembler : random byte stream checked against a byte/pixel
// counting reference model; honours `define RX_TIMEOUT_EN like the design.
module tb_uart_pixel_assembler;

  localparam int IMG_W       = 8;
  localparam int IMG_H       = 4;
  localparam int NPIX        = IMG_W * IMG_H;
  localparam int TIMEOUT_CYC = 16;
  localparam int CW          = $clog2(NPIX);
`ifdef RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic [23:0]   pixel_data;
  logic          pixel_done;
  logic [CW-1:0] pixel_cnt;
  logic          frame_done;
  logic          busy;
  logic          rx_timeout;

  uart_pixel_assembler #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .pixel_data(pixel_data),
    .pixel_done(pixel_done),
    .pixel_cnt (pixel_cnt),
    .frame_done(frame_done),
    .busy      (busy),
    .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pd_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte list per pixel, running pixel total since reset.
  int          m_pix;
  int          m_nb;
  int          m_idle;
  logic [7:0]  m_part [2];
  logic        e_pd, e_fd, e_to, e_busy;
  logic [23:0] e_data;

  task automatic model_reset();
    m_pix = 0; m_nb = 0; m_idle = 0;
    e_pd = 0; e_fd = 0; e_to = 0; e_busy = 0; e_data = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    e_fd = e_pd && (m_pix % NPIX == 0);
    if (e_fd) e_busy = 0;
    e_pd = 0;
    e_to = 0;
    if (v) begin
      if (m_nb == 0) e_busy = 1;
      m_idle = 0;
      if (m_nb == 2) begin
        e_data = {m_part[0], m_part[1], d};
        e_pd   = 1;
        m_pix++;
        m_nb   = 0;
      end else begin
        m_part[m_nb] = d;
        m_nb++;
      end
    end else if (TO_EN && m_nb > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT_CYC) begin
        m_nb = 0; m_idle = 0; e_to = 1;
      end
    end
  endtask

  task automatic check_outs();
    int e_cnt;
    e_cnt = e_pd ? (m_pix - 1) % NPIX : m_pix % NPIX;
    check("pixel_done", 32'(pixel_done), 32'(e_pd));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("rx_timeout", 32'(rx_timeout), 32'(e_to));
    check("busy",       32'(busy),       32'(e_busy));
    check("pixel_cnt",  32'(pixel_cnt),  32'(e_cnt));
    check("pixel_data", 32'(pixel_data), 32'(e_data));
    if (pixel_done) pd_seen++;
  endtask

  task automatic cycle(input bit v, input logic [7:0] d);
    rx_done = v;
    rx_data = d;
    @(posedge clk);
    model_step(v, d);
    #1;
    check_outs();
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check_outs();
    @(posedge clk);
    #3;
    reset = 1'b1;
    cycle(1'b0, 8'h00);
  endtask

  initial begin
    int pd_start;
    model_reset();
    #2;
    check_outs();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    cycle(1'b0, 8'h00);

    // Single pixel with gaps between bytes.
    pd_start = pd_seen;
    cycle(1'b1, 8'h11);
    idle(2);
    cycle(1'b1, 8'h22);
    cycle(1'b1, 8'h33);
    check("p0_done", 32'(pixel_done), 32'd1);
    check("p0_data", 32'(pixel_data), 32'h112233);
    check("p0_cnt",  32'(pixel_cnt),  32'd0);

    // Rest of frame back-to-back, then next R byte in the frame_done cycle.
    for (int i = 0; i < (NPIX - 1) * 3; i++) cycle(1'b1, 8'($urandom));
    check("last_cnt", 32'(pixel_cnt), 32'(NPIX - 1));
    cycle(1'b0, 8'h00);
    check("frame_pd_count", 32'(pd_seen - pd_start), 32'(NPIX));
    check("fd_pulse", 32'(frame_done), 32'd1);
    check("fd_cnt",   32'(pixel_cnt),  32'd0);
    check("fd_busy",  32'(busy),       32'd0);
    cycle(1'b1, 8'hA1);
    cycle(1'b1, 8'hA2);
    cycle(1'b1, 8'hA3);
    check("nf_data", 32'(pixel_data), 32'hA1A2A3);
    check("nf_cnt",  32'(pixel_cnt),  32'd0);

    // Continuous stream across two more frame boundaries.
    for (int i = 0; i < NPIX * 6; i++) cycle(1'b1, 8'($urandom));

    // Reset mid-pixel discards the partial pixel.
    cycle(1'b1, 8'hAA);
    cycle(1'b1, 8'hBB);
    do_reset();
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    check("rst_data", 32'(pixel_data), 32'h010203);
    check("rst_cnt",  32'(pixel_cnt),  32'd0);

    // Inter-byte timeout scenario.
    idle(3);
    cycle(1'b1, 8'h55);
    idle(TIMEOUT_CYC);
    check("to_pulse", 32'(rx_timeout), 32'(TO_EN));
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    check("to_pd_b", 32'(pixel_done), 32'(!TO_EN));
    cycle(1'b1, 8'h03);
    check("to_pd_c",  32'(pixel_done), 32'(TO_EN));
    check("to_data",  32'(pixel_data), TO_EN ? 32'h010203 : 32'h550102);

    // Random traffic with occasional long gaps.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)
        idle($urandom_range(10, 20));
      else
        cycle($urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
